demapper_stream_wifi: RTL and testbench
=======================================

// Module: demapper_stream_wifi
// PURPOSE
//  Runtime-configurable hard-decision WiFi demapper with built-in buffered serializer.
//  Accepts one complex symbol per handshake and demaps it per the 802.11a Gray tables,
//  with the modulation (BPSK/QPSK/16QAM/64QAM) selected per symbol.
//  Queues NBPSC-bit words in a small FIFO and streams them out one bit per handshake.
//  Sits between equaliser output and deinterleaver/decoder; replaces per-mode build-time variants.
// PARAMETERS
//  DATA_W      12    signed I/Q sample width (two's complement)
//  FIFO_DEPTH  4     demapped-word FIFO entries (power of 2, >=2)
//  TH16        12'd648   16QAM inner decision threshold |x| (2 units, 16QAM scale)
//  TH64_2      12'd316   64QAM threshold 2 units (64QAM scale)
//  TH64_4      12'd632   64QAM threshold 4 units
//  TH64_6      12'd948   64QAM threshold 6 units
// PORTS
//  clk            in   1        single clock
//  reset          in   1        asynchronous, active-low reset
//  flush          in   1        sync clear of FIFO and serializer (1-cycle pulse)
//  mod_sel        in   2        0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM; sampled with each symbol
//  valid_in       in   1        symbol valid
//  ready_out      out  1        block can accept a symbol (= FIFO not full)
//  data_in_real   in   DATA_W   I sample
//  data_in_imag   in   DATA_W   Q sample
//  valid_out      out  1        data_out holds a valid bit
//  ready_in       in   1        downstream accepts bit
//  data_out       out  1        serial hard bit, b0 of each symbol first
//  fifo_level     out  log2(FIFO_DEPTH)+1  words currently queued (excl. serializer)
// BEHAVIOUR
//  Reset (reset=0): ready_out=0 while asserted, then 1; valid_out=0, data_out=0, fifo_level=0.
//  Accept: edge with valid_in&ready_out. Demap is combinational; word+NBPSC written to FIFO same edge.
//  NBPSC: BPSK 1, QPSK 2, 16QAM 4, 64QAM 6. mod_sel stored per entry; mixed modes legal.
//  Sign: x>=0 -> 1 (zero counts positive). |x| of most-negative value saturates to max positive.
//  BPSK: b0=sgn(I); Q ignored. QPSK: b0=sgn(I), b1=sgn(Q).
//  16QAM: b0=sgn(I), b1=(|I|<TH16), b2=sgn(Q), b3=(|Q|<TH16).
//  64QAM: b0=sgn(I), b1=(|I|<TH64_4), b2=(TH64_2<=|I|<TH64_6); b3..b5 same from Q.
//  Serializer states: IDLE (valid_out=0) / SHIFT (valid_out=1, bit counter).
//   IDLE & FIFO non-empty -> load head word, SHIFT next cycle; first bit on data_out after the load edge.
//   Latency: symbol accepted at edge k into empty block -> valid_out=1 with b0 after edge k+1.
//   SHIFT: bit advances only on valid_out&ready_in; ready_in=0 holds data_out stable.
//   Last bit handshaked & FIFO non-empty -> load next word same edge (no bubble);
//   last bit handshaked & FIFO empty -> IDLE.
//  FIFO: ready_out = (fifo_level<FIFO_DEPTH). Push and pop same edge -> level unchanged.
//   Push while full impossible (ready_out=0); no overflow/underflow state exists.
//  flush=1: FIFO emptied, serializer -> IDLE, valid_out=0 next cycle; a symbol offered
//   in the flush cycle is dropped. flush has priority over all other events.
//  reset mid-stream: all state cleared immediately, partial symbol discarded.
// TESTING
//  1 BPSK I=+100,-100,0 (ready_in=1) -> data_out 1,0,1 on consecutive cycles, first after edge k+1.
//  2 QPSK (I,Q)=(-5,+7) -> bits 0,1; 16QAM (I,Q)=(+300,-900) -> bits 1,1,0,0.
//  3 64QAM (I,Q)=(+500,-1000) -> bits 1,1,1,0,0,0; I=-2048 saturates -> b1=0,b2=0.
//  4 ready_in=0 for 20 cycles, stream 64QAM -> fifo_level reaches 4, ready_out=0, no symbol lost; data_out stable.
//  5 Alternate BPSK/64QAM back-to-back with ready_in=1 -> 1,6,1,6... bits, no idle cycles between symbols.
//  6 flush mid-symbol with 3 queued -> valid_out=0, fifo_level=0 next cycle; reset=0 mid-shift -> outputs at reset values.

Source files
------------

// File: rtl/demapper_stream_wifi.sv
// demapper_stream_wifi
//   Hard-decision 802.11a demapper with a per-symbol selectable modulation
//   (BPSK/QPSK/16QAM/64QAM). It queues demapped words in a small FIFO and
//   streams them out one bit per handshake, with b0 of each symbol first.
//
// Ports
//   clk           single clock
//   reset         asynchronous, active-low reset
//   flush         synchronous clear of the FIFO and the serializer
//   mod_sel       0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM; sampled with each symbol
//   valid_in      symbol valid
//   ready_out     a symbol can be accepted (FIFO not full)
//   data_in_real  I sample, two's complement
//   data_in_imag  Q sample, two's complement
//   valid_out     data_out holds a valid bit
//   ready_in      downstream accepts the bit
//   data_out      serial hard bit
//   fifo_level    words queued in the FIFO (the word in the serializer is excluded)

module demapper_stream_wifi #(
    parameter int unsigned       DATA_W     = 12,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] TH16       = 12'd648,
    parameter logic [DATA_W-1:0] TH64_2     = 12'd316,
    parameter logic [DATA_W-1:0] TH64_4     = 12'd632,
    parameter logic [DATA_W-1:0] TH64_6     = 12'd948
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [1:0]                    mod_sel,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [DATA_W-1:0]             data_in_real,
    input  logic [DATA_W-1:0]             data_in_imag,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          data_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {StIdle, StShift} ser_state_e;

    // Magnitude of a two's complement sample; the most-negative value saturates
    // to the largest positive value so it still lands in the outermost region.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] n;
        if (!x[DATA_W-1]) begin
            return x;
        end
        n = ~x + 1'b1;
        if (n[DATA_W-1]) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return n;
    endfunction

    function automatic logic [2:0] nbpsc(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Combinational demap
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mag_i;
    logic [DATA_W-1:0] mag_q;
    logic              sgn_i;
    logic              sgn_q;
    logic [5:0]        demap_word;

    always_comb begin
        mag_i      = mag(data_in_real);
        mag_q      = mag(data_in_imag);
        // Zero counts as positive.
        sgn_i      = ~data_in_real[DATA_W-1];
        sgn_q      = ~data_in_imag[DATA_W-1];
        demap_word = '0;
        case (mod_sel)
            2'd0: begin
                demap_word[0] = sgn_i;
            end
            2'd1: begin
                demap_word[0] = sgn_i;
                demap_word[1] = sgn_q;
            end
            2'd2: begin
                demap_word[0] = sgn_i;
                demap_word[1] = (mag_i < TH16);
                demap_word[2] = sgn_q;
                demap_word[3] = (mag_q < TH16);
            end
            default: begin
                demap_word[0] = sgn_i;
                demap_word[1] = (mag_i < TH64_4);
                demap_word[2] = (mag_i >= TH64_2) && (mag_i < TH64_6);
                demap_word[3] = sgn_q;
                demap_word[4] = (mag_q < TH64_4);
                demap_word[5] = (mag_q >= TH64_2) && (mag_q < TH64_6);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [5:0]       word_mem [FIFO_DEPTH];
    logic [1:0]       mode_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             rdy_en_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [5:0]       head_word;
    logic [1:0]       head_mode;

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    // rdy_en_q keeps ready_out low while reset is asserted.
    assign ready_out  = rdy_en_q & ~fifo_full;
    assign push       = valid_in & ready_out & ~flush;
    assign head_word  = word_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_mode  = mode_mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q[PTR_W-1:0]] <= demap_word;
            mode_mem[wr_ptr_q[PTR_W-1:0]] <= mod_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    ser_state_e state_q;
    ser_state_e state_d;
    logic [5:0] sh_q;
    logic [2:0] idx_q;
    logic [2:0] nbits_q;
    logic       load;
    logic       last_bit;
    logic       bit_hs;

    assign last_bit = (idx_q == nbits_q - 3'd1);
    assign bit_hs   = (state_q == StShift) & ready_in;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        valid_out = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                valid_out = 1'b1;
                if (ready_in && last_bit) begin
                    // Chain straight into the next word to avoid a bubble.
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (flush) begin
            state_d = StIdle;
            load    = 1'b0;
        end
    end

    assign pop      = load;
    assign data_out = sh_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sh_q    <= '0;
            idx_q   <= '0;
            nbits_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                sh_q    <= '0;
                idx_q   <= '0;
                nbits_q <= '0;
            end else if (load) begin
                sh_q    <= head_word;
                idx_q   <= '0;
                nbits_q <= nbpsc(head_mode);
            end else if (bit_hs) begin
                if (last_bit) begin
                    sh_q  <= '0;
                    idx_q <= '0;
                end else begin
                    sh_q  <= sh_q >> 1;
                    idx_q <= idx_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demapper_stream_wifi.sv
// Scoreboard bench for demapper_stream_wifi: the driver pushes the expected bits
// of every accepted symbol into a queue; a negedge monitor pops and compares
// every bit the DUT hands over.
module tb_demapper_stream_wifi;

    localparam int DATA_W     = 12;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [1:0]        mod_sel;
    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] data_in_real;
    logic [DATA_W-1:0] data_in_imag;
    logic              valid_out;
    logic              ready_in;
    logic              data_out;
    logic [2:0]        fifo_level;

    demapper_stream_wifi dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .mod_sel      (mod_sel),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_in_real (data_in_real),
        .data_in_imag (data_in_imag),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    bit rand_ready = 0;
    bit busy_chk   = 0;
    bit seen_valid = 0;
    bit hold_v     = 0;
    bit hold_bit   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference demap from the 802.11a decision rules, plain integer arithmetic.
    function automatic void model(input int m, input int i, input int q);
        int ai;
        int aq;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai > 2047) ai = 2047;
        if (aq > 2047) aq = 2047;
        exp_q.push_back(i >= 0);
        if (m == 1) begin
            exp_q.push_back(q >= 0);
        end else if (m == 2) begin
            exp_q.push_back(ai < 648);
            exp_q.push_back(q >= 0);
            exp_q.push_back(aq < 648);
        end else if (m == 3) begin
            exp_q.push_back(ai < 632);
            exp_q.push_back(ai >= 316 && ai < 948);
            exp_q.push_back(q >= 0);
            exp_q.push_back(aq < 632);
            exp_q.push_back(aq >= 316 && aq < 948);
        end
    endfunction

    // Monitor: compare every handed-over bit, and stability while stalled.
    always @(negedge clk) begin
        if (!reset) begin
            hold_v = 0;
        end else begin
            if (busy_chk) begin
                if (seen_valid) begin
                    chk("no_bubble", int'(valid_out), int'(exp_q.size() > 0));
                end
                if (valid_out) seen_valid = 1;
            end
            if (valid_out) begin
                if (hold_v) chk("hold_stable", int'(data_out), int'(hold_bit));
                if (ready_in) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bit: got %0d expected none at %0t",
                                 data_out, $time);
                    end else begin
                        chk("data_out", int'(data_out), int'(exp_q.pop_front()));
                    end
                    hold_v = 0;
                end else begin
                    hold_v   = 1;
                    hold_bit = data_out;
                end
            end else begin
                hold_v = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
    endtask

    task automatic offer(input int m, input int i, input int q, input int bound,
                         output bit acc);
        mod_sel      = 2'(m);
        data_in_real = DATA_W'(i);
        data_in_imag = DATA_W'(q);
        valid_in     = 1'b1;
        acc          = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (ready_out && !flush) begin
                model(m, i, q);
                acc = 1;
            end
            step();
            if (acc) break;
        end
        valid_in = 1'b0;
    endtask

    task automatic send(input int m, input int i, input int q);
        bit acc;
        offer(m, i, q, 200, acc);
        chk("accept_timeout", int'(acc), 1);
    endtask

    task automatic wait_drain(input int bound);
        bit done;
        done = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !valid_out) begin
                done = 1;
                break;
            end
            step();
        end
        chk("drain_timeout", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_sample();
        int edges[13] = '{647, 648, -648, 315, 316, -631, 632, 947, -948, 0, -1, -2048, 2047};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 12)];
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        reset        = 1'b0;
        flush        = 1'b0;
        mod_sel      = 2'd0;
        valid_in     = 1'b0;
        data_in_real = '0;
        data_in_imag = '0;
        ready_in     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready_out", int'(ready_out), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_ready", int'(ready_out), 1);
        step();

        // 1: BPSK and first-bit latency
        ready_in = 1'b1;
        send(0, 100, 0);
        @(negedge clk);
        chk("latency_k", int'(valid_out), 0);
        @(negedge clk);
        chk("latency_k1", int'(valid_out), 1);
        step();
        send(0, -100, 0);
        send(0, 0, 0);
        wait_drain(50);

        // 2, 3: QPSK, 16QAM, 64QAM, saturation
        send(1, -5, 7);
        send(2, 300, -900);
        send(3, 500, -1000);
        send(3, -2048, 2047);
        wait_drain(100);

        // 4: backpressure fills the FIFO
        ready_in = 1'b0;
        for (int n = 0; n < 5; n++) send(3, rand_sample(), rand_sample());
        offer(3, 123, -456, 3, acc);
        chk("full_reject", int'(acc), 0);
        @(negedge clk);
        chk("full_level", int'(fifo_level), 4);
        chk("full_ready_out", int'(ready_out), 0);
        repeat (10) step();
        ready_in = 1'b1;
        wait_drain(200);

        // 5: alternating BPSK/64QAM back-to-back, no bubbles
        busy_chk   = 1;
        seen_valid = 0;
        for (int n = 0; n < 10; n++) begin
            if (n % 2 == 0) send(0, rand_sample(), rand_sample());
            else            send(3, rand_sample(), rand_sample());
        end
        wait_drain(200);
        busy_chk = 0;

        // 6a: flush mid-symbol with 3 queued
        ready_in = 1'b0;
        for (int n = 0; n < 4; n++) send(3, rand_sample(), rand_sample());
        @(negedge clk);
        chk("pre_flush_level", int'(fifo_level), 3);
        step();
        ready_in = 1'b1;
        repeat (2) step();
        ready_in     = 1'b0;
        flush        = 1'b1;
        valid_in     = 1'b1;
        mod_sel      = 2'd3;
        data_in_real = DATA_W'(500);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        valid_in = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_valid_out", int'(valid_out), 0);
        chk("flush_level", int'(fifo_level), 0);
        step();
        ready_in = 1'b1;
        wait_drain(20);

        // 6b: asynchronous reset mid-shift
        ready_in = 1'b0;
        for (int n = 0; n < 3; n++) send(3, rand_sample(), rand_sample());
        ready_in = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid_out", int'(valid_out), 0);
        chk("midrst_data_out", int'(data_out), 0);
        chk("midrst_level", int'(fifo_level), 0);
        chk("midrst_ready_out", int'(ready_out), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
        @(negedge clk);
        chk("post_midrst_ready", int'(ready_out), 1);
        step();

        // Random mixed traffic with random backpressure
        rand_ready = 1;
        for (int n = 0; n < 80; n++) begin
            send(int'($urandom_range(0, 3)), rand_sample(), rand_sample());
            if ($urandom_range(0, 4) == 0) step();
        end
        wait_drain(2000);
        rand_ready = 0;
        ready_in   = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
